// File: rtl/cube_pkg.sv
// Shared types and constants for the cube-state scanner and the move sequencer.
// Holds face/turn encodings, the 5-bit move record, the sequencer FSM states,
// the colour codes used by the scanner, and a face-to-one-hot helper.
package cube_pkg;

  localparam int unsigned FACE_W    = 3;
  localparam int unsigned TURN_W    = 2;
  localparam int unsigned MOVE_W    = FACE_W + TURN_W;
  localparam int unsigned NUM_FACES = 6;

  // Face indices; also the bit positions of step/dir.
  localparam logic [FACE_W-1:0] FACE_U = 3'd0;
  localparam logic [FACE_W-1:0] FACE_L = 3'd1;
  localparam logic [FACE_W-1:0] FACE_F = 3'd2;
  localparam logic [FACE_W-1:0] FACE_R = 3'd3;
  localparam logic [FACE_W-1:0] FACE_B = 3'd4;
  localparam logic [FACE_W-1:0] FACE_D = 3'd5;

  // Turn codes; TURN_END delimits a segment.
  localparam logic [TURN_W-1:0] TURN_END  = 2'd0;
  localparam logic [TURN_W-1:0] TURN_CW   = 2'd1;
  localparam logic [TURN_W-1:0] TURN_HALF = 2'd2;
  localparam logic [TURN_W-1:0] TURN_CCW  = 2'd3;

  // Colour codes shared with the scanner.
  localparam logic [2:0] COL_W = 3'd0;
  localparam logic [2:0] COL_O = 3'd1;
  localparam logic [2:0] COL_G = 3'd2;
  localparam logic [2:0] COL_R = 3'd3;
  localparam logic [2:0] COL_B = 3'd4;
  localparam logic [2:0] COL_Y = 3'd5;

  typedef struct packed {
    logic [FACE_W-1:0] face;
    logic [TURN_W-1:0] turn;
  } move_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_STEP_HI,
    ST_STEP_LO,
    ST_SETTLE,
    ST_DONE
  } state_e;

  // One-hot motor select; faces 6 and 7 select nothing (no-op turn).
  function automatic logic [NUM_FACES-1:0] face_onehot(input logic [FACE_W-1:0] face);
    logic [NUM_FACES-1:0] oh;
    oh = '0;
    case (face)
      3'd0:    oh = 6'b000001;
      3'd1:    oh = 6'b000010;
      3'd2:    oh = 6'b000100;
      3'd3:    oh = 6'b001000;
      3'd4:    oh = 6'b010000;
      3'd5:    oh = 6'b100000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/move_rom.sv
// Move ROM: DEPTH x 5-bit entries, synchronous read (data valid the cycle
// after addr is presented). Contents come in as a packed image, entry i at
// bits [5*i +: 5]; the build flow converts the setup-batch hex file into it.
// Ports: clock; addr (entry index); data (registered move record).
module move_rom
  import cube_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter logic [DEPTH*MOVE_W-1:0] IMAGE = '0
) (
  input  logic          clock,
  input  logic [AW-1:0] addr,
  output move_t         data
);

  int unsigned rd_idx;
  move_t       data_q;

  always_comb rd_idx = 32'(addr) * MOVE_W;

  // Registered read; no reset needed as the sequencer only uses data in LOAD.
  always_ff @(posedge clock) begin
    data_q <= IMAGE[rd_idx +: MOVE_W];
  end

  assign data = data_q;

endmodule

// File: rtl/move_sequencer.sv
// Move sequencer: responder to the scanner's send_setup_moves request. Each
// request plays the next END-delimited segment of the move ROM as step/dir
// pulses on six face steppers, then pulses done_turning for one cycle.
// Ports:
//   clock, reset_n       - clock, async active-low reset
//   send_setup_moves     - one-cycle request for the next segment
//   step[5:0], dir[5:0]  - per-face step pulse and direction (1 = CW), U,L,F,R,B,D
//   done_turning         - one-cycle pulse at segment end
//   busy                 - high from request accept until done_turning
//   seg_count[5:0]       - completed segments, modulo 64
module move_sequencer
  import cube_pkg::*;
#(
  parameter int unsigned STEPS_PER_QUARTER = 50,
  parameter int unsigned STEP_HALF_CYCLES  = 32500,
  parameter int unsigned SETTLE_CYCLES     = 65000,
  parameter int unsigned ROM_DEPTH         = 256,
  parameter logic [ROM_DEPTH*MOVE_W-1:0] ROM_IMAGE = '0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send_setup_moves,
  output logic [5:0] step,
  output logic [5:0] dir,
  output logic       done_turning,
  output logic       busy,
  output logic [5:0] seg_count
);

  localparam int unsigned PTR_W      = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int unsigned BUDGET_MAX = 2 * STEPS_PER_QUARTER;
  localparam int unsigned BUDGET_W   = $clog2(BUDGET_MAX + 1);
  localparam int unsigned TIMER_MAX  =
    ((STEP_HALF_CYCLES > SETTLE_CYCLES) ? STEP_HALF_CYCLES : SETTLE_CYCLES) - 1;
  localparam int unsigned TIMER_W    = (TIMER_MAX > 0) ? $clog2(TIMER_MAX + 1) : 1;

  localparam logic [TIMER_W-1:0]  HALF_RELOAD   = TIMER_W'(STEP_HALF_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  SETTLE_RELOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [BUDGET_W-1:0] BUDGET_QTR    = BUDGET_W'(STEPS_PER_QUARTER);
  localparam logic [BUDGET_W-1:0] BUDGET_HALF   = BUDGET_W'(BUDGET_MAX);
  localparam logic [PTR_W-1:0]    PTR_LAST      = PTR_W'(ROM_DEPTH - 1);

  state_e                 state_q,   state_d;
  logic [PTR_W-1:0]       ptr_q,     ptr_d;
  logic                   pending_q, pending_d;
  logic [FACE_W-1:0]      face_q,    face_d;
  logic [BUDGET_W-1:0]    budget_q,  budget_d;
  logic [TIMER_W-1:0]     timer_q,   timer_d;
  logic [5:0]             step_q,    step_d;
  logic [5:0]             dir_q,     dir_d;
  logic                   done_q,    done_d;
  logic                   busy_q,    busy_d;
  logic [5:0]             seg_q,     seg_d;

  move_t                  rom_data;
  logic [PTR_W-1:0]       ptr_next;
  logic [5:0]             rom_oh;

  move_rom #(
    .DEPTH (ROM_DEPTH),
    .AW    (PTR_W),
    .IMAGE (ROM_IMAGE)
  ) u_rom (
    .clock (clock),
    .addr  (ptr_q),
    .data  (rom_data)
  );

  // Pointer increment wraps from the last entry back to 0.
  always_comb begin
    ptr_next = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
    rom_oh   = face_onehot(rom_data.face);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pending_d = pending_q;
    face_d    = face_q;
    budget_d  = budget_q;
    timer_d   = timer_q;
    step_d    = step_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    seg_d     = seg_q;

    // Requests outside IDLE collapse into one pending start (DONE included).
    if (send_setup_moves && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (send_setup_moves || pending_q) begin
          pending_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_FETCH: begin
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        ptr_d = ptr_next;
        if (rom_data.turn == TURN_END) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          seg_d   = seg_q + 6'd1;
          state_d = ST_DONE;
        end else begin
          face_d   = rom_data.face;
          budget_d = (rom_data.turn == TURN_HALF) ? BUDGET_HALF : BUDGET_QTR;
          if (rom_oh != '0) begin
            dir_d   = (rom_data.turn == TURN_CCW) ? '0 : rom_oh;
            step_d  = rom_oh;
            timer_d = HALF_RELOAD;
            state_d = ST_STEP_HI;
          end else begin
            // Faces 6/7: no pulses, but the settle delay still applies.
            dir_d   = '0;
            timer_d = SETTLE_RELOAD;
            state_d = ST_SETTLE;
          end
        end
      end

      ST_STEP_HI: begin
        if (timer_q == '0) begin
          step_d  = '0;
          timer_d = HALF_RELOAD;
          state_d = ST_STEP_LO;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      ST_STEP_LO: begin
        if (timer_q == '0) begin
          budget_d = budget_q - BUDGET_W'(1);
          if (budget_q != BUDGET_W'(1)) begin
            step_d  = face_onehot(face_q);
            timer_d = HALF_RELOAD;
            state_d = ST_STEP_HI;
          end else begin
            dir_d   = '0;
            timer_d = SETTLE_RELOAD;
            state_d = ST_SETTLE;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      ST_SETTLE: begin
        if (timer_q == '0) begin
          state_d = ST_FETCH;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops step/dir immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      pending_q <= 1'b0;
      face_q    <= '0;
      budget_q  <= '0;
      timer_q   <= '0;
      step_q    <= '0;
      dir_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      seg_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      face_q    <= face_d;
      budget_q  <= budget_d;
      timer_q   <= timer_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      seg_q     <= seg_d;
    end
  end

  assign step         = step_q;
  assign dir          = dir_q;
  assign done_turning = done_q;
  assign busy         = busy_q;
  assign seg_count    = seg_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer with a 6-entry ROM [U CW, END, F CCW, B HALF, END, END].
// Stimulus pushes the expected step/done events into a queue; a negedge
// monitor turns DUT activity into events and compares them in order.
module tb_move_sequencer;
  import cube_pkg::*;

  localparam int SPQ    = 4;
  localparam int HALFC  = 2;
  localparam int SETTLE = 3;
  localparam int unsigned DEPTH = 6;
  localparam logic [DEPTH*MOVE_W-1:0] ROM_IMG =
    {5'h00, 5'h00, 5'h12, 5'h0B, 5'h00, 5'h01};

  localparam int EV_STEP = 0;
  localparam int EV_DONE = 1;

  typedef struct packed {
    int kind;
    int face;
    int dirv;
    int t;
    int len;
    int seg;
    int busy;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       send_setup_moves = 1'b0;
  logic [5:0] step, dir, seg_count;
  logic       done_turning, busy;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  ev_t exp_q[$];

  move_sequencer #(
    .STEPS_PER_QUARTER (SPQ),
    .STEP_HALF_CYCLES  (HALFC),
    .SETTLE_CYCLES     (SETTLE),
    .ROM_DEPTH         (DEPTH),
    .ROM_IMAGE         (ROM_IMG)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .send_setup_moves (send_setup_moves),
    .step             (step),
    .dir              (dir),
    .done_turning     (done_turning),
    .busy             (busy),
    .seg_count        (seg_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic ev_t mk_ev(input int kind, input int face, input int dirv,
                                input int t, input int len, input int seg, input int bsy);
    ev_t e;
    e.kind = kind; e.face = face; e.dirv = dirv; e.t = t;
    e.len = len; e.seg = seg; e.busy = bsy;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_event(input ev_t a);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d face=%0d t=%0d, expected no event",
               a.kind, a.face, a.t);
    end else begin
      e = exp_q.pop_front();
      if (a != e) begin
        n_fail++;
        $display("FAIL event: got kind=%0d face=%0d dir=%0d t=%0d len=%0d seg=%0d busy=%0d, expected kind=%0d face=%0d dir=%0d t=%0d len=%0d seg=%0d busy=%0d",
                 a.kind, a.face, a.dirv, a.t, a.len, a.seg, a.busy,
                 e.kind, e.face, e.dirv, e.t, e.len, e.seg, e.busy);
      end
    end
  endtask

  // Monitor: step pulses reported at their falling edge with rise time and width.
  logic [5:0] prev_step = '0;
  int rise_t[6];
  int rise_dir[6];
  int rise_busy[6];
  int hi_len[6];

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_step = '0;
    end else begin
      n_checks++;
      if (!$onehot0(step)) begin
        n_fail++;
        $display("FAIL step_onehot: got step=%b, expected at most one bit set", step);
      end
      for (int f = 0; f < 6; f++) begin
        if (step[f] && !prev_step[f]) begin
          rise_t[f] = cyc; rise_dir[f] = int'(dir[f]);
          rise_busy[f] = int'(busy); hi_len[f] = 1;
        end else if (step[f]) begin
          hi_len[f]++;
        end else if (prev_step[f]) begin
          check_event(mk_ev(EV_STEP, f, (int'(dir[f]) == rise_dir[f]) ? rise_dir[f] : -1,
                            rise_t[f], hi_len[f], 0, rise_busy[f]));
        end
      end
      if (done_turning) begin
        check_event(mk_ev(EV_DONE, 0, int'(dir != '0), cyc, 0, int'(seg_count), int'(busy)));
      end
      prev_step = step;
    end
  end

  // Model: t is the cycle the FSM sits in FETCH; advanced to the next FETCH.
  task automatic push_turn(inout int t, input int face, input int turn);
    int n;
    int dv;
    n  = (turn == 2) ? 2 * SPQ : SPQ;
    dv = (turn == 3) ? 0 : 1;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(mk_ev(EV_STEP, face, dv, t + 2 + k * 2 * HALFC, HALFC, 0, 1));
    end
    t = t + 2 + n * 2 * HALFC + SETTLE;
  endtask

  task automatic push_end(inout int t, input int seg, output int d);
    d = t + 2;
    exp_q.push_back(mk_ev(EV_DONE, 0, 0, d, 0, seg, 0));
    t = d;
  endtask

  // Drives a one-cycle request in the current cycle; c = that cycle.
  task automatic pulse_req(output int c);
    send_setup_moves = 1'b1;
    c = cyc;
    @(posedge clock); #1;
    send_setup_moves = 1'b0;
  endtask

  task automatic wait_cycle(input int target);
    int i;
    i = 0;
    while (cyc < target && i < 20000) begin
      @(posedge clock); #1;
      i++;
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < limit) begin
      @(posedge clock); #1;
      i++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d events outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test by time %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    int c, c2, t, d;

    repeat (3) @(posedge clock);
    #1;
    check("rst_step", int'(step), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_done", int'(done_turning), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_seg", int'(seg_count), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Segment 1: U CW.
    pulse_req(c);
    check("busy_accept", int'(busy), 1);
    t = c + 1; push_turn(t, 0, 1); push_end(t, 1, d);
    wait_drain("seg1", 300);
    check("seg1_count", int'(seg_count), 1);
    check("seg1_busy", int'(busy), 0);

    // Segment 2: F CCW then B HALF.
    pulse_req(c);
    t = c + 1; push_turn(t, 2, 3); push_turn(t, 4, 2); push_end(t, 2, d);
    wait_drain("seg2", 300);
    check("seg2_count", int'(seg_count), 2);

    // Segment 3: empty, pointer wraps; segment 4 replays U CW.
    pulse_req(c);
    t = c + 1; push_end(t, 3, d);
    wait_drain("seg3", 50);
    pulse_req(c);
    t = c + 1; push_turn(t, 0, 1); push_end(t, 4, d);
    wait_drain("seg4", 300);

    // Two requests while busy collapse into one extra segment.
    pulse_req(c);
    t = c + 1; push_turn(t, 2, 3); push_turn(t, 4, 2); push_end(t, 5, d);
    wait_cycle(c + 5);  pulse_req(c2);
    wait_cycle(c + 10); pulse_req(c2);
    t = d + 2; push_end(t, 6, d);
    wait_drain("pending", 400);
    repeat (20) @(posedge clock);
    #1;
    check("pending_idle_busy", int'(busy), 0);
    check("pending_seg", int'(seg_count), 6);

    // Request in the DONE cycle is latched.
    pulse_req(c);
    t = c + 1; push_turn(t, 0, 1); push_end(t, 7, d);
    wait_cycle(d);
    check("done_coincident", int'(done_turning), 1);
    pulse_req(c2);
    t = d + 2; push_turn(t, 2, 3); push_turn(t, 4, 2); push_end(t, 8, d);
    wait_drain("coincident", 400);

    // Empty segment at entry 5 wraps the pointer, then reset mid STEP_HI.
    pulse_req(c);
    t = c + 1; push_end(t, 9, d);
    wait_drain("seg9", 50);
    pulse_req(c);
    wait_cycle(c + 3);
    check("pre_reset_step", int'(step), 1);
    check("pre_reset_dir", int'(dir), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_step", int'(step), 0);
    check("async_dir", int'(dir), 0);
    check("async_busy", int'(busy), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    check("post_reset_step", int'(step), 0);
    check("post_reset_seg", int'(seg_count), 0);
    check("post_reset_busy", int'(busy), 0);
    pulse_req(c);
    t = c + 1; push_turn(t, 0, 1); push_end(t, 1, d);
    wait_drain("replay", 300);
    check("replay_seg", int'(seg_count), 1);

    repeat (10) @(posedge clock);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
